// File: rtl/noc_pkg.sv
// Shared NoC types: direction encoding, flit payload layout and XY routing.
package noc_pkg;

    localparam int unsigned DEF_ADDR_W     = 2;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_WEST  = 3'd4
    } dir_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]     dest_x;
        logic [DEF_ADDR_W-1:0]     dest_y;
        logic [DEF_DATA_WIDTH-1:0] data;
    } flit_t;

    // Dimension-ordered routing: resolve X first, then Y; coordinates are zero-extended.
    function automatic dir_t xy_route(input int unsigned dest_x, input int unsigned dest_y,
                                      input int unsigned my_x, input int unsigned my_y);
        if (dest_x > my_x)      return DIR_EAST;
        else if (dest_x < my_x) return DIR_WEST;
        else if (dest_y > my_y) return DIR_SOUTH;
        else if (dest_y < my_y) return DIR_NORTH;
        else                    return DIR_LOCAL;
    endfunction

endpackage

// File: rtl/node_input_port_if.sv
// Ingress/egress handshake bundle of one node input port.
// INPORT_STATS_EN adds the flits_in / stall_cycles counters.
interface node_input_port_if
    import noc_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [ADDR_W-1:0]     in_dest_x;
    logic [ADDR_W-1:0]     in_dest_y;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    dir_t                  out_dir;
    logic [ADDR_W-1:0]     out_dest_x;
    logic [ADDR_W-1:0]     out_dest_y;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_grant;
    logic [CNT_W-1:0]      occupancy;
`ifdef INPORT_STATS_EN
    logic [15:0]           flits_in;
    logic [15:0]           stall_cycles;
`endif

    modport master (
        output in_valid, in_dest_x, in_dest_y, in_data, out_grant,
        input  in_ready, out_valid, out_dir, out_dest_x, out_dest_y, out_data, occupancy
`ifdef INPORT_STATS_EN
        , input flits_in, stall_cycles
`endif
    );

    modport slave (
        input  in_valid, in_dest_x, in_dest_y, in_data, out_grant,
        output in_ready, out_valid, out_dir, out_dest_x, out_dest_y, out_data, occupancy
`ifdef INPORT_STATS_EN
        , output flits_in, stall_cycles
`endif
    );

endinterface

// File: rtl/flit_fifo.sv
// Generic synchronous FIFO with separate occupancy count; no empty bypass.
module flit_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_input_port.sv
// Per-link NoC ingress: buffers flits, routes them XY at push time, presents the head.
// INPORT_STATS_EN adds saturating push / stall counters.
module node_input_port
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MY_X       = 0,
    parameter int unsigned MY_Y       = 0
) (
    input logic              clk,
    input logic              reset,
    node_input_port_if.slave port
);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = 3 + 2 * ADDR_W + DATA_WIDTH;

    typedef struct packed {
        dir_t                  dir;
        logic [ADDR_W-1:0]     dest_x;
        logic [ADDR_W-1:0]     dest_y;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t           wr_entry;
    entry_t           rd_entry;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;

    assign push = port.in_valid && !full;
    assign pop  = port.out_grant && !empty;

    // Route is resolved on the way in so the head path is a plain register read.
    always_comb begin
        wr_entry        = '0;
        wr_entry.dir    = xy_route(32'(port.in_dest_x), 32'(port.in_dest_y), MY_X, MY_Y);
        wr_entry.dest_x = port.in_dest_x;
        wr_entry.dest_y = port.in_dest_y;
        wr_entry.data   = port.in_data;
    end

    flit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign port.in_ready  = !full;
    assign port.out_valid = !empty;
    assign port.occupancy = count;

    always_comb begin
        port.out_dir    = DIR_LOCAL;
        port.out_dest_x = '0;
        port.out_dest_y = '0;
        port.out_data   = '0;
        if (!empty) begin
            port.out_dir    = rd_entry.dir;
            port.out_dest_x = rd_entry.dest_x;
            port.out_dest_y = rd_entry.dest_y;
            port.out_data   = rd_entry.data;
        end
    end

`ifdef INPORT_STATS_EN
    logic [15:0] flits_in_q;
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flits_in_q <= '0;
            stall_q    <= '0;
        end else begin
            if (push && (flits_in_q != 16'hFFFF))
                flits_in_q <= flits_in_q + 16'd1;
            if (port.in_valid && full && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
        end
    end

    assign port.flits_in     = flits_in_q;
    assign port.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_node_input_port.sv
// Directed vector bench for node_input_port at node (1,1), DEPTH=4.
module tb_node_input_port;
    import noc_pkg::*;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    node_input_port_if #(.ADDR_W(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    node_input_port #(
        .DATA_WIDTH (DW),
        .ADDR_W     (AW),
        .DEPTH      (DEPTH),
        .MY_X       (1),
        .MY_Y       (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .port  (bus.slave)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic [31:0] data;
        logic        grant;
        logic        e_ready;
        logic        e_valid;
        dir_t        e_dir;
        logic [1:0]  e_dx;
        logic [1:0]  e_dy;
        logic [31:0] e_data;
        int          e_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, int dx, int dy, logic [31:0] d, logic g,
                                logic er, logic ev, dir_t edir, int edx, int edy,
                                logic [31:0] ed, int eo);
        vec_t t;
        t.valid = v;      t.dx = 2'(dx);     t.dy = 2'(dy);   t.data = d;  t.grant = g;
        t.e_ready = er;   t.e_valid = ev;    t.e_dir = edir;
        t.e_dx = 2'(edx); t.e_dy = 2'(edy);  t.e_data = ed;   t.e_occ = eo;
        return t;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, int dx, int dy, logic [31:0] d, logic g);
        bus.in_valid  = v;
        bus.in_dest_x = 2'(dx);
        bus.in_dest_y = 2'(dy);
        bus.in_data   = d;
        bus.out_grant = g;
    endtask

    // Pre-edge state check of the head outputs.
    task automatic chk_head(string tag, logic er, logic ev, dir_t edir, int edx, int edy,
                            logic [31:0] ed, int eo);
        chk({tag, ".in_ready"},  longint'(bus.in_ready),   longint'(er));
        chk({tag, ".out_valid"}, longint'(bus.out_valid),  longint'(ev));
        chk({tag, ".out_dir"},   longint'(bus.out_dir),    longint'(edir));
        chk({tag, ".dest_x"},    longint'(bus.out_dest_x), longint'(edx));
        chk({tag, ".dest_y"},    longint'(bus.out_dest_y), longint'(edy));
        chk({tag, ".out_data"},  longint'(bus.out_data),   longint'(ed));
        chk({tag, ".occupancy"}, longint'(bus.occupancy),  longint'(eo));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 0, 0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 chk_head($sformatf("idle%0d", i), 1'b1, 1'b0, DIR_LOCAL, 0, 0, 32'h0, 0);
        end

        // Routing order and payload ordering.
        vecs.push_back(mk(1, 3, 1, 32'hA000_0000, 0, 1, 0, DIR_LOCAL, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 1, 32'hA000_0001, 0, 1, 1, DIR_EAST,  3, 1, 32'hA000_0000, 1));
        vecs.push_back(mk(1, 1, 3, 32'hA000_0002, 1, 1, 1, DIR_EAST,  3, 1, 32'hA000_0000, 2));
        vecs.push_back(mk(1, 1, 0, 32'hA000_0003, 1, 1, 1, DIR_WEST,  0, 1, 32'hA000_0001, 2));
        vecs.push_back(mk(1, 1, 1, 32'hA000_0004, 1, 1, 1, DIR_SOUTH, 1, 3, 32'hA000_0002, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 1, DIR_NORTH, 1, 0, 32'hA000_0003, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 1, DIR_LOCAL, 1, 1, 32'hA000_0004, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 0, DIR_LOCAL, 0, 0, 32'h0, 0));
        // Fill to full, hold a 5th, one grant admits it, then drain.
        vecs.push_back(mk(1, 2, 1, 32'hB000_0000, 0, 1, 0, DIR_LOCAL, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 2, 1, 32'hB000_0001, 0, 1, 1, DIR_EAST,  2, 1, 32'hB000_0000, 1));
        vecs.push_back(mk(1, 2, 1, 32'hB000_0002, 0, 1, 1, DIR_EAST,  2, 1, 32'hB000_0000, 2));
        vecs.push_back(mk(1, 2, 1, 32'hB000_0003, 0, 1, 1, DIR_EAST,  2, 1, 32'hB000_0000, 3));
        vecs.push_back(mk(1, 0, 0, 32'hB000_0004, 0, 0, 1, DIR_EAST,  2, 1, 32'hB000_0000, 4));
        vecs.push_back(mk(1, 0, 0, 32'hB000_0004, 1, 0, 1, DIR_EAST,  2, 1, 32'hB000_0000, 4));
        vecs.push_back(mk(1, 0, 0, 32'hB000_0004, 0, 1, 1, DIR_EAST,  2, 1, 32'hB000_0001, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 1, DIR_EAST,  2, 1, 32'hB000_0001, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 1, DIR_EAST,  2, 1, 32'hB000_0001, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 1, DIR_EAST,  2, 1, 32'hB000_0002, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 1, DIR_EAST,  2, 1, 32'hB000_0003, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 1, DIR_WEST,  0, 0, 32'hB000_0004, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 0, DIR_LOCAL, 0, 0, 32'h0, 0));
        // Streaming push+grant: one-cycle latency, occupancy steady at 1.
        vecs.push_back(mk(1, 1, 2, 32'hC000_0000, 1, 1, 0, DIR_LOCAL, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 2, 32'hC000_0001, 1, 1, 1, DIR_SOUTH, 1, 2, 32'hC000_0000, 1));
        vecs.push_back(mk(1, 1, 2, 32'hC000_0002, 1, 1, 1, DIR_SOUTH, 1, 2, 32'hC000_0001, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 1, DIR_SOUTH, 1, 2, 32'hC000_0002, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 0, DIR_LOCAL, 0, 0, 32'h0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].valid, int'(vecs[i].dx), int'(vecs[i].dy), vecs[i].data, vecs[i].grant);
            #1 chk_head($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_dir,
                        int'(vecs[i].e_dx), int'(vecs[i].e_dy), vecs[i].e_data, vecs[i].e_occ);
        end

        // Reset with 3 flits buffered discards them.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 0, 1, 32'hE000_0000 + 32'(i), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 0, 0, 32'h0, 1'b0);
        #1 chk("pre_reset.occupancy", longint'(bus.occupancy), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk_head("post_reset", 1'b1, 1'b0, DIR_LOCAL, 0, 0, 32'h0, 0);
        drive(1'b1, 2, 2, 32'hF000_0000, 1'b0);
        @(negedge clk);
        drive(1'b0, 0, 0, 32'h0, 1'b1);
        #1 chk_head("fresh_head", 1'b1, 1'b1, DIR_EAST, 2, 2, 32'hF000_0000, 1);
        @(negedge clk);
        drive(1'b0, 0, 0, 32'h0, 1'b0);
        #1 chk_head("fresh_drained", 1'b1, 1'b0, DIR_LOCAL, 0, 0, 32'h0, 0);

`ifdef INPORT_STATS_EN
        // Counters: 4 accepted pushes, then 7 cycles stalled on full.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("stats_rst.flits_in", longint'(bus.flits_in), 0);
        chk("stats_rst.stall", longint'(bus.stall_cycles), 0);
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1, 1, 32'h5000_0000 + 32'(i), 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 0, 0, 32'h0, 1'b0);
        #1 chk("stats.flits_in", longint'(bus.flits_in), 4);
        chk("stats.stall_cycles", longint'(bus.stall_cycles), 7);
        chk("stats.occupancy", longint'(bus.occupancy), 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/node_input_port.md
Name: node_input_port

Overview:
- Per-link ingress stage of a NoC node (node3/node4/node5).
- Accepts single-flit packets from a neighbour or the local interface and buffers them in a small FIFO.
- Computes the dimension-ordered (XY) output direction of each flit and presents the head flit to the node's switch arbiter.
- The arbiter consumes it on grant; one instance sits in front of each node port.

Parameters:
- DATA_WIDTH, 32, payload bits per flit.
- ADDR_W, 2, bits per coordinate; NOC_SIZE <= 2**ADDR_W.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MY_X, 0, node column.
- MY_Y, 0, node row.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream flit valid.
- in_dest_x  in  ADDR_W  destination column.
- in_dest_y  in  ADDR_W  destination row.
- in_data  in  DATA_WIDTH  payload.
- in_ready  out  1  buffer can accept a flit this cycle.
- out_valid  out  1  head flit available.
- out_dir  out  3  requested output: dir_t.
- out_dest_x  out  ADDR_W  head destination column.
- out_dest_y  out  ADDR_W  head destination row.
- out_data  out  DATA_WIDTH  head payload.
- out_grant  in  1  arbiter accepts head flit this cycle.
- occupancy  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Reset (synchronous, on clk, reset=1):
  - rd_ptr, wr_ptr and count go to 0.
  - Outputs go to in_ready=1, out_valid=0, out_dir=DIR_LOCAL, out_dest_x/y=0, out_data=0, occupancy=0.
  - Reset asserted mid-operation discards all buffered flits.
- in_ready = (count < DEPTH), combinational from registered count.
- Push when in_valid && in_ready. No push is ever taken while full; an in_valid seen while full is ignored and the upstream holds it.
- Pop when out_valid && out_grant. out_grant while empty is ignored, with no pointer change.
- Simultaneous push+pop:
  - Legal whenever not full; count unchanged.
  - When full, in_ready=0, so the pop alone occurs; no same-cycle bypass.
- Latency: a flit pushed at edge t appears on out_* after edge t, i.e. out_valid can rise one cycle after in_valid. There is no empty-FIFO bypass.
- Head outputs:
  - out_* reflect entry[rd_ptr] when count>0.
  - When empty, out_data/dest are driven 0 and out_dir is DIR_LOCAL.
- Ordering is strict FIFO. Pointers wrap modulo DEPTH, with count tracked separately.
- Routing is computed at push and stored with the entry, so it is not on the output timing path. XY order:
  - dest_x > MY_X -> DIR_EAST.
  - dest_x < MY_X -> DIR_WEST.
  - Else dest_y > MY_Y -> DIR_SOUTH.
  - Else dest_y < MY_Y -> DIR_NORTH.
  - Else DIR_LOCAL.
- Coordinate comparisons are unsigned on ADDR_W bits.
- occupancy = count. It steps by +1 on push-only and -1 on pop-only.

Optional Feature:
- Macro: INPORT_STATS_EN.
- Defined:
  - Adds output flits_in[15:0], which counts accepted pushes.
  - Adds output stall_cycles[15:0], which counts cycles with in_valid && !in_ready.
  - Both are saturating at 16'hFFFF and cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package noc_pkg:
  - dir_t enum logic [2:0]: DIR_LOCAL=0, DIR_NORTH=1, DIR_EAST=2, DIR_SOUTH=3, DIR_WEST=4.
  - flit_t packed struct {dest_x, dest_y, data}.
  - Default ADDR_W/DATA_WIDTH constants.
  - Function xy_route(dest_x, dest_y, my_x, my_y) returning dir_t.
- Sub-module flit_fifo: a generic DEPTH x (flit_t + dir_t) synchronous FIFO with push/pop/count. node_input_port wraps it with the routing logic and stats.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, occupancy=0, out_dir=DIR_LOCAL for 10 cycles.
- MY_X=1, MY_Y=1; push dests (3,1), (0,1), (1,3), (1,0), (1,1) -> out_dir sequence EAST, WEST, SOUTH, NORTH, LOCAL; payloads preserved in order.
- Push 4 flits with out_grant=0 -> occupancy=4, in_ready=0. A 5th in_valid is held and not accepted. One grant -> the 5th is accepted the following cycle and occupancy returns to 4.
- Continuous in_valid and out_grant from empty -> first out_valid one cycle after first push, then 1 flit/cycle throughput, occupancy steady at 1.
- Reset asserted with 3 flits buffered -> next cycle occupancy=0, out_valid=0; later pushes start from a fresh head.
- With INPORT_STATS_EN: hold full for 7 cycles with in_valid=1 -> stall_cycles=7; flits_in equals the accepted count.
